// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU-side system bus master: FSM encoding and a width helper.
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BUS = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_RETRY    = 3'd3,
        ST_DONE     = 3'd4
    } bus_state_e;

    // Index width that stays legal for a single channel.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_bus_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module cpu_bus_rr_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IW     = idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IW-1:0]     ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [IW-1:0]     idx_o
);

    int   c;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = (int'(ptr_i) + k) % NUM_CH;
            if (!found && req_i[c]) begin
                found    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/cpu_bus_master.sv
// CPU-side master for the shared tri-state system bus: round-robin over NUM_CH
// channels, watchdog on the slave acknowledge and bounded automatic re-issue.
module cpu_bus_master
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_CH      = 2,
    parameter int TIMEOUT_CYC = 256,
    parameter int MAX_RETRY   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       bus_req,
    input  logic                       bus_grant,
    output logic [ADDR_W-1:0]          addr_bus,
    inout  wire  [DATA_W-1:0]          data_bus,
    output logic                       rd_bus,
    output logic                       wr_bus,
    output logic [DATA_W/8-1:0]        data_mask_bus,
    input  logic                       fc_bus,
    input  logic [NUM_CH-1:0]          ch_rd_req,
    input  logic [NUM_CH-1:0]          ch_wr_req,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
    input  logic [NUM_CH*DATA_W/8-1:0] ch_mask,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic [NUM_CH-1:0]          ch_done,
    output logic [NUM_CH-1:0]          ch_timeout,
    output logic                       busy
);

    localparam int MASK_W = DATA_W / 8;
    localparam int IW     = idx_w(NUM_CH);
    localparam int WW     = $clog2(TIMEOUT_CYC + 1);
    localparam int RW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    bus_state_e        state_q, state_d;
    logic [IW-1:0]     sel_q, sel_d, rr_q, rr_d;
    logic [WW-1:0]     wd_q, wd_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic              bus_req_q, bus_req_d;
    logic              is_wr_q, is_wr_d;
    logic [NUM_CH-1:0] done_q, done_d, tmo_q, tmo_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [MASK_W-1:0] mask_q, mask_d;

    logic [NUM_CH-1:0] req, arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic              drv;

    logic [ADDR_W-1:0] addr_a  [NUM_CH];
    logic [DATA_W-1:0] wdata_a [NUM_CH];
    logic [MASK_W-1:0] mask_a  [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign addr_a[i]  = ch_addr[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = ch_wdata[i*DATA_W +: DATA_W];
        assign mask_a[i]  = ch_mask[i*MASK_W +: MASK_W];
    end

    assign req = ch_rd_req | ch_wr_req;

    cpu_bus_rr_arbiter #(.NUM_CH(NUM_CH), .IW(IW)) u_arb (
        .req_i (req),
        .ptr_i (rr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // Lines float whenever we do not own the bus, so reset releases them at once.
    assign drv           = bus_grant & bus_req_q;
    assign addr_bus      = drv ? mar_q : 'z;
    assign data_mask_bus = drv ? mask_q : 'z;
    assign rd_bus        = drv ? !is_wr_q : 1'bz;
    assign wr_bus        = drv ? is_wr_q : 1'bz;
    assign data_bus      = (drv && is_wr_q) ? mdr_q : 'z;

    assign bus_req    = bus_req_q;
    assign ch_rdata   = mdr_q;
    assign ch_done    = done_q;
    assign ch_timeout = tmo_q;
    assign busy       = (state_q != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_d      = rr_q;
        wd_d      = wd_q;
        retry_d   = retry_q;
        bus_req_d = bus_req_q;
        is_wr_d   = is_wr_q;
        done_d    = done_q;
        tmo_d     = tmo_q;
        mar_d     = mar_q;
        mdr_d     = mdr_q;
        mask_d    = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    sel_d     = arb_idx;
                    mar_d     = addr_a[arb_idx];
                    mask_d    = mask_a[arb_idx];
                    // A channel raising both strobes is treated as a write.
                    is_wr_d   = |(arb_gnt & ch_wr_req);
                    if (is_wr_d) mdr_d = wdata_a[arb_idx];
                    bus_req_d = 1'b1;
                    retry_d   = '0;
                    state_d   = ST_WAIT_BUS;
                end
            end
            ST_WAIT_BUS: begin
                if (bus_grant) begin
                    wd_d    = '0;
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (fc_bus) begin
                    done_d[sel_q] = 1'b1;
                    bus_req_d     = 1'b0;
                    if (!is_wr_q) mdr_d = data_bus;
                    state_d       = ST_DONE;
                end else if (wd_q == WW'(TIMEOUT_CYC - 1)) begin
                    bus_req_d = 1'b0;
                    if (int'(retry_q) < MAX_RETRY) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_RETRY;
                    end else begin
                        tmo_d[sel_q] = 1'b1;
                        state_d      = ST_DONE;
                    end
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_RETRY: begin
                bus_req_d = 1'b1;
                state_d   = ST_WAIT_BUS;
            end
            ST_DONE: begin
                if (!ch_rd_req[sel_q] && !ch_wr_req[sel_q]) begin
                    done_d  = '0;
                    tmo_d   = '0;
                    rr_d    = (int'(sel_q) == NUM_CH - 1) ? '0 : sel_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            rr_q      <= '0;
            wd_q      <= '0;
            retry_q   <= '0;
            bus_req_q <= 1'b0;
            is_wr_q   <= 1'b0;
            done_q    <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rr_q      <= rr_d;
            wd_q      <= wd_d;
            retry_q   <= retry_d;
            bus_req_q <= bus_req_d;
            is_wr_q   <= is_wr_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
        end
    end

    // Transfer registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        mar_q  <= mar_d;
        mdr_q  <= mdr_d;
        mask_q <= mask_d;
    end

endmodule
